// File: rtl/tlk2711_tx_sched_if.sv
// Handshake bundle between the TLK2711 TX scheduler, the DDR datamover
// (read-command channel) and the TX framer (frame start/done channel).
//   master : scheduler side (drives read commands and frame starts)
//   slave  : datamover/framer side (drives ready and frame done)
// Signal names match the original flat ports of tlk2711_tx_sched.
interface tlk2711_tx_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  o_rd_cmd_valid;
    logic                  i_rd_cmd_ready;
    logic [ADDR_WIDTH-1:0] o_rd_cmd_addr;
    logic [LEN_WIDTH-1:0]  o_rd_cmd_len;
    logic                  o_frame_start;
    logic [LEN_WIDTH-1:0]  o_frame_len;
    logic                  o_frame_last;
    logic [3:0]            o_frame_mode;
    logic                  i_frame_done;

    modport master (
        output o_rd_cmd_valid, o_rd_cmd_addr, o_rd_cmd_len,
        output o_frame_start, o_frame_len, o_frame_last, o_frame_mode,
        input  i_rd_cmd_ready, i_frame_done
    );

    modport slave (
        input  o_rd_cmd_valid, o_rd_cmd_addr, o_rd_cmd_len,
        input  o_frame_start, o_frame_len, o_frame_last, o_frame_mode,
        output i_rd_cmd_ready, i_frame_done
    );
endinterface

// File: rtl/tlk2711_tx_sched.sv
// TLK2711 TX file-transfer scheduler.
// After a config-done pulse the file is split into body packets plus an
// optional tail packet. Each packet gets one DDR read command (normal mode
// only) followed by one frame start to the framer; the last frame-done
// raises a one-cycle TX interrupt.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_tx_*              TX configuration, latched on i_tx_config_done in idle
//   bus (master)        read-command channel and frame start/done channel
//   o_tx_interrupt      one-cycle pulse when the file is complete
//   o_busy              transfer in progress
//   o_pkt_cnt           packets completed in the current file
module tlk2711_tx_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_tx_packet_body,
    input  logic [LEN_WIDTH-1:0]  i_tx_packet_tail,
    input  logic [15:0]           i_tx_body_num,
    input  logic [3:0]            i_tx_mode,
    input  logic                  i_tx_config_done,
    tlk2711_tx_sched_if.master    bus,
    output logic                  o_tx_interrupt,
    output logic                  o_busy,
    output logic [15:0]           o_pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMD,
        FRAME,
        WAIT,
        DONE
    } state_t;

    state_t                state;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  body_len;
    logic [LEN_WIDTH-1:0]  tail_len;
    logic [15:0]           body_num;
    logic [16:0]           total;
    logic [16:0]           idx;

    logic                  rd_cmd_valid;
    logic [ADDR_WIDTH-1:0] rd_cmd_addr;
    logic [LEN_WIDTH-1:0]  rd_cmd_len;
    logic                  frame_start;
    logic [LEN_WIDTH-1:0]  frame_len;
    logic                  frame_last;
    logic [3:0]            frame_mode;

    logic [16:0]           total_in;
    logic [LEN_WIDTH-1:0]  next_len;

    // 17 bits so that 65535 bodies plus a tail does not overflow.
    assign total_in = 17'(i_tx_body_num) + ((i_tx_packet_tail != '0) ? 17'd1 : 17'd0);
    assign next_len = (idx < {1'b0, body_num}) ? body_len : tail_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cur_addr       <= '0;
            body_len       <= '0;
            tail_len       <= '0;
            body_num       <= '0;
            total          <= '0;
            idx            <= '0;
            rd_cmd_valid   <= 1'b0;
            rd_cmd_addr    <= '0;
            rd_cmd_len     <= '0;
            frame_start    <= 1'b0;
            frame_len      <= '0;
            frame_last     <= 1'b0;
            frame_mode     <= '0;
            o_tx_interrupt <= 1'b0;
            o_busy         <= 1'b0;
            o_pkt_cnt      <= '0;
        end else begin
            frame_start    <= 1'b0;
            o_tx_interrupt <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tx_config_done) begin
                        cur_addr   <= i_tx_base_addr;
                        body_len   <= i_tx_packet_body;
                        tail_len   <= i_tx_packet_tail;
                        body_num   <= i_tx_body_num;
                        frame_mode <= i_tx_mode;
                        total      <= total_in;
                        idx        <= '0;
                        o_pkt_cnt  <= '0;
                        o_busy     <= 1'b1;
                        state      <= (total_in == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    frame_len  <= next_len;
                    frame_last <= (idx == total - 17'd1);
                    if (frame_mode == 4'd0) begin
                        rd_cmd_valid <= 1'b1;
                        rd_cmd_addr  <= cur_addr;
                        rd_cmd_len   <= next_len;
                        state        <= CMD;
                    end else begin
                        // Loopback/kcode packets need no DDR data.
                        frame_start <= 1'b1;
                        state       <= FRAME;
                    end
                end
                CMD: begin
                    if (bus.i_rd_cmd_ready) begin
                        rd_cmd_valid <= 1'b0;
                        frame_start  <= 1'b1;
                        state        <= FRAME;
                    end
                end
                FRAME: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.i_frame_done) begin
                        o_pkt_cnt <= o_pkt_cnt + 16'd1;
                        idx       <= idx + 17'd1;
                        cur_addr  <= cur_addr + ADDR_WIDTH'(frame_len);
                        state     <= frame_last ? DONE : LOAD;
                    end
                end
                DONE: begin
                    o_tx_interrupt <= 1'b1;
                    o_busy         <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_rd_cmd_valid = rd_cmd_valid;
    assign bus.o_rd_cmd_addr  = rd_cmd_addr;
    assign bus.o_rd_cmd_len   = rd_cmd_len;
    assign bus.o_frame_start  = frame_start;
    assign bus.o_frame_len    = frame_len;
    assign bus.o_frame_last   = frame_last;
    assign bus.o_frame_mode   = frame_mode;

endmodule
